// File: rtl/mul_pkg.sv
// Shared types and constants for the multi-cycle MUL/MLA sequencer.
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_FINISH = 2'd2
    } mul_state_t;

    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MOV = 4'b1101;

    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    localparam int WIDTH_DEF = 32;

endpackage

// File: rtl/mul_seq.sv
// Shift-and-add MUL/MLA sequencer that borrows the shared ALU for each partial-product add.
// Optional macro MUL_EARLY_TERM_EN: leave ACCUM once the remaining multiplier bits are all zero.
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_in,
    input  logic [WIDTH-1:0] rm_in,
    input  logic [WIDTH-1:0] rs_in,
    input  logic [WIDTH-1:0] rn_in,
    input  logic             acc_in,
    input  logic             s_in,
    input  logic [3:0]       cpsr_flags_in,
    input  logic [WIDTH-1:0] alu_result_in,
    output logic [WIDTH-1:0] alu_a_out,
    output logic [WIDTH-1:0] alu_b_out,
    output logic [3:0]       alu_opcode_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] result_out,
    output logic [3:0]       flags_out,
    output logic             flags_we_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_q, s_d;
    logic [1:0]       cv_q, cv_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             last_step;

    // N and Z are regenerated from the product; only V/C are carried through.
    logic [1:0] unused_nz;
    assign unused_nz = cpsr_flags_in[1:0];

    always_comb begin
        state_d        = state_q;
        mcand_d        = mcand_q;
        mplier_d       = mplier_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        s_d            = s_q;
        cv_d           = cv_q;
        result_d       = result_q;
        last_step      = 1'b0;
        busy_out       = 1'b0;
        done_out       = 1'b0;
        flags_we_out   = 1'b0;
        flags_out      = 4'b0000;
        alu_a_out      = '0;
        alu_b_out      = '0;
        alu_opcode_out = OP_ADD;

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    mcand_d  = rm_in;
                    mplier_d = rs_in;
                    acc_d    = acc_in ? rn_in : '0;
                    cnt_d    = '0;
                    s_d      = s_in;
                    cv_d     = cpsr_flags_in[FLAG_V:FLAG_C];
                    state_d  = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                busy_out  = 1'b1;
                alu_a_out = acc_q;
                alu_b_out = mplier_q[0] ? mcand_q : '0;
                acc_d     = alu_result_in;
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                cnt_d     = cnt_q + 1'b1;
`ifdef MUL_EARLY_TERM_EN
                last_step = (cnt_q == CNT_LAST) || ((mplier_q >> 1) == '0);
`else
                last_step = (cnt_q == CNT_LAST);
`endif
                if (last_step) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                busy_out          = 1'b1;
                done_out          = 1'b1;
                result_d          = acc_q;
                flags_we_out      = s_q;
                flags_out[FLAG_V] = cv_q[1];
                flags_out[FLAG_C] = cv_q[0];
                flags_out[FLAG_Z] = (acc_q == '0);
                flags_out[FLAG_N] = acc_q[WIDTH-1];
                state_d           = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Operand datapath is only observed in ACCUM/FINISH, so it carries no reset.
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        acc_q    <= acc_d;
        s_q      <= s_d;
        cv_q     <= cv_d;
    end

    assign result_out = result_q;

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: expected products queued at issue, checked by a done_out monitor.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_in;
    logic [31:0] rm_in, rs_in, rn_in;
    logic        acc_in, s_in;
    logic [3:0]  cpsr_flags_in;
    logic [31:0] alu_result_in;
    logic [31:0] alu_a_out, alu_b_out;
    logic [3:0]  alu_opcode_out;
    logic        busy_out, done_out, flags_we_out;
    logic [31:0] result_out;
    logic [3:0]  flags_out;

    mul_seq dut (
        .clk            (clk),
        .reset          (reset),
        .start_in       (start_in),
        .rm_in          (rm_in),
        .rs_in          (rs_in),
        .rn_in          (rn_in),
        .acc_in         (acc_in),
        .s_in           (s_in),
        .cpsr_flags_in  (cpsr_flags_in),
        .alu_result_in  (alu_result_in),
        .alu_a_out      (alu_a_out),
        .alu_b_out      (alu_b_out),
        .alu_opcode_out (alu_opcode_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .result_out     (result_out),
        .flags_out      (flags_out),
        .flags_we_out   (flags_we_out)
    );

    always #5 clk = ~clk;

    // Shared ALU stand-in: only ADD is meaningful to the sequencer.
    assign alu_result_in = (alu_opcode_out == 4'b0100) ? (alu_a_out + alu_b_out) : 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        logic        we;
        int          t0;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    bit          res_pending = 0;
    logic [31:0] res_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] rm, input logic [31:0] rs, input logic [31:0] rn,
                                   input logic acc, input logic s, input logic [3:0] cpsr, input int t0);
        exp_t e;
        longint unsigned prod;
        int msb;
        prod    = longint'(rm) * longint'(rs) + (acc ? longint'(rn) : 64'd0);
        e.res   = prod[31:0];
        e.flags = {cpsr[3], cpsr[2], e.res == 32'd0, e.res[31]};
        e.we    = s;
        e.t0    = t0;
        msb     = -1;
        for (int i = 0; i < 32; i++) if (rs[i]) msb = i;
`ifdef MUL_EARLY_TERM_EN
        e.lat = (msb < 0) ? 2 : 2 + msb;
`else
        e.lat = 33;
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (res_pending) begin
                chk("result", result_out, res_exp);
                chk("idle_after_done", {31'd0, busy_out}, 32'd0);
                res_pending = 0;
            end
            if (flags_we_out && !done_out) begin
                n_vec++;
                n_err++;
                $display("FAIL flags_we_without_done: flags_we=1 done=0 (cycle %0d)", cyc);
            end
            if (done_out) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_done: done=1 with nothing outstanding (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("latency", 32'(cyc - e.t0), 32'(e.lat));
                    chk("flags", {28'd0, flags_out}, {28'd0, e.flags});
                    chk("flags_we", {31'd0, flags_we_out}, {31'd0, e.we});
                    res_exp     = e.res;
                    res_pending = 1;
                end
            end
        end
    end

    task automatic wait_idle();
        int w = 0;
        @(negedge clk);
        while (busy_out && w < 80) begin
            @(negedge clk);
            w++;
        end
        if (busy_out) chk("idle_timeout", {31'd0, busy_out}, 32'd0);
    endtask

    task automatic launch(input logic [31:0] rm, input logic [31:0] rs, input logic [31:0] rn,
                          input logic acc, input logic s, input logic [3:0] cpsr, input bit expect_done);
        wait_idle();
        rm_in = rm; rs_in = rs; rn_in = rn; acc_in = acc; s_in = s; cpsr_flags_in = cpsr;
        start_in = 1'b1;
        if (expect_done) exp_q.push_back(model(rm, rs, rn, acc, s, cpsr, cyc));
        @(negedge clk);
        start_in = 1'b0;
        rm_in = $urandom; rs_in = $urandom; rn_in = $urandom;
        acc_in = 1'($urandom); s_in = 1'($urandom); cpsr_flags_in = 4'($urandom);
        chk("busy_after_start", {31'd0, busy_out}, 32'd1);
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || res_pending) && w < 80) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) chk("done_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_op(input logic [31:0] rm, input logic [31:0] rs, input logic [31:0] rn,
                         input logic acc, input logic s, input logic [3:0] cpsr);
        launch(rm, rs, rn, acc, s, cpsr, 1'b1);
        drain();
    endtask

    initial begin
        reset = 1'b1; start_in = 1'b0;
        rm_in = '0; rs_in = '0; rn_in = '0; acc_in = 1'b0; s_in = 1'b0; cpsr_flags_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy_out}, 32'd0);
        chk("rst_done", {31'd0, done_out}, 32'd0);
        chk("rst_result", result_out, 32'd0);
        chk("rst_flags", {28'd0, flags_out}, 32'd0);
        chk("rst_flags_we", {31'd0, flags_we_out}, 32'd0);
        chk("rst_opcode", {28'd0, alu_opcode_out}, 32'h4);
        chk("rst_alu_a", alu_a_out, 32'd0);
        chk("rst_alu_b", alu_b_out, 32'd0);
        reset = 1'b0;

        do_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 4'b0000);
        do_op(32'hFFFF_FFFF, 32'd2, 32'd5, 1'b1, 1'b1, 4'b1100);
        do_op(32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1, 4'b0000);
        do_op(32'h0001_2345, 32'd0, 32'd0, 1'b0, 1'b1, 4'b0000);
        do_op(32'd9, 32'd3, 32'd0, 1'b0, 1'b0, 4'b0000);

        // Start pulse while busy must be dropped.
        launch(32'd1000, 32'hFFFF_FFFF, 32'd3, 1'b1, 1'b1, 4'b0100, 1'b1);
        repeat (4) @(negedge clk);
        rm_in = 32'd55; rs_in = 32'd66; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // Reset mid-operation: no completion, result cleared.
        launch(32'd123, 32'hF000_0001, 32'd0, 1'b0, 1'b1, 4'b0000, 1'b0);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy_out}, 32'd0);
        chk("midrst_done", {31'd0, done_out}, 32'd0);
        chk("midrst_flags_we", {31'd0, flags_we_out}, 32'd0);
        chk("midrst_result", result_out, 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        do_op(32'd11, 32'd13, 32'd100, 1'b1, 1'b1, 4'b0011);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] rs_r;
            rs_r = $urandom >> $urandom_range(0, 31);
            do_op($urandom, rs_r, $urandom, 1'($urandom), 1'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
